// File: rtl/wire_ops_packer.sv
// Packs WireOps result bytes little-endian into 32-bit words with byte count and
// XOR checksum, buffered in a first-word-fall-through FIFO toward a valid/ready port.
module wire_ops_packer #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [2:0]       out_count,
    output logic [7:0]       out_csum,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [1:0]       lane_q;
    logic [31:0]      asm_q;
    logic [7:0]       acc_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;

    logic [31:0] mem_data_q [DEPTH];
    logic [2:0]  mem_cnt_q  [DEPTH];
    logic [7:0]  mem_csum_q [DEPTH];

    logic [31:0] asm_d;
    logic [7:0]  acc_d;
    logic [2:0]  eff_cnt;
    logic        push_req, push_ok, pop;

    // Lanes above the current one are always zero, so the assembly register
    // with this cycle's byte merged in is already the zero-padded word.
    always_comb begin
        asm_d = asm_q;
        acc_d = acc_q;
        if (in_valid) begin
            asm_d[{lane_q, 3'b000} +: 8] = in_data;
            acc_d = acc_q ^ in_data;
        end
        eff_cnt  = {1'b0, lane_q} + {2'b00, in_valid};
        push_req = (in_valid && lane_q == 2'd3) || (flush && eff_cnt != 3'd0);
        pop      = out_valid && out_ready;
        push_ok  = push_req && (level_q != FULL_LVL || pop);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            lane_q     <= '0;
            asm_q      <= '0;
            acc_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_req) begin
                lane_q <= '0;
                asm_q  <= '0;
                acc_q  <= '0;
            end else if (in_valid) begin
                lane_q <= lane_q + 2'd1;
                asm_q  <= asm_d;
                acc_q  <= acc_d;
            end
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)
                level_q <= level_q + LVL_W'(1);
            else if (!push_ok && pop)
                level_q <= level_q - LVL_W'(1);
            if (push_req && !push_ok) overflow_q <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem_data_q[wr_ptr_q] <= asm_d;
            mem_cnt_q[wr_ptr_q]  <= eff_cnt;
            mem_csum_q[wr_ptr_q] <= acc_d;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
    assign out_count = out_valid ? mem_cnt_q[rd_ptr_q]  : '0;
    assign out_csum  = out_valid ? mem_csum_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wire_ops_packer.sv
// Directed and randomized bench for wire_ops_packer, checked every cycle against
// a queue-based model of the byte packing and word FIFO.
module tb_wire_ops_packer;

    localparam int DEPTH = 4;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic [7:0]  out_csum;
    logic [2:0]  level;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  c;
        logic [7:0]  s;
    } word_t;

    word_t      fifo_m[$];
    logic [7:0] pend_m[$];
    bit         ovf_m;

    wire_ops_packer #(.DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_csum  (out_csum),
        .level     (level),
        .overflow  (overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of one clock edge, using the inputs applied during the cycle.
    task automatic model_edge(input logic rn, input logic iv, input logic [7:0] d,
                              input logic fl, input logic ordy);
        word_t w;
        bit    pop;
        if (!rn) begin
            fifo_m.delete();
            pend_m.delete();
            ovf_m = 1'b0;
            return;
        end
        pop = (fifo_m.size() > 0) && ordy;
        if (iv) pend_m.push_back(d);
        if (pop) void'(fifo_m.pop_front());
        if (pend_m.size() == 4 || (fl && pend_m.size() > 0)) begin
            w.d = 32'h0;
            w.s = 8'h0;
            w.c = 3'(pend_m.size());
            for (int k = 0; k < pend_m.size(); k++) begin
                w.d = w.d | (32'(pend_m[k]) << (8 * k));
                w.s = w.s ^ pend_m[k];
            end
            if (fifo_m.size() < DEPTH) fifo_m.push_back(w);
            else ovf_m = 1'b1;
            pend_m.delete();
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = fifo_m.size() > 0;
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_data",  out_data,       v ? fifo_m[0].d : 32'h0);
        chk("out_count", 32'(out_count), v ? 32'(fifo_m[0].c) : 32'h0);
        chk("out_csum",  32'(out_csum),  v ? 32'(fifo_m[0].s) : 32'h0);
        chk("level",     32'(level),     32'(fifo_m.size()));
        chk("overflow",  32'(overflow),  32'(ovf_m));
    endtask

    task automatic tick(input logic rn, input logic iv, input logic [7:0] d,
                        input logic fl, input logic ordy);
        sys_rst_n = rn;
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        @(posedge sys_clk);
        model_edge(rn, iv, d, fl, ordy);
        #1;
        check_outputs();
    endtask

    task automatic byte_in(input logic [7:0] d, input logic ordy);
        tick(1'b1, 1'b1, d, 1'b0, ordy);
    endtask

    task automatic idle(input logic ordy);
        tick(1'b1, 1'b0, 8'h00, 1'b0, ordy);
    endtask

    initial begin
        ovf_m = 1'b0;
        tick(1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset_level", 32'(level), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);

        // Full word
        byte_in(8'h11, 1'b1);
        byte_in(8'h22, 1'b1);
        byte_in(8'h33, 1'b1);
        chk("full_early_valid", 32'(out_valid), 32'h0);
        byte_in(8'h44, 1'b1);
        chk("full_data", out_data, 32'h44332211);
        chk("full_count", 32'(out_count), 32'd4);
        chk("full_csum", 32'(out_csum), 32'h44);
        idle(1'b1);
        chk("full_drop", 32'(out_valid), 32'h0);

        // Partial words and flush
        byte_in(8'hA5, 1'b1);
        byte_in(8'h5A, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("flush2_data", out_data, 32'h00005AA5);
        chk("flush2_count", 32'(out_count), 32'd2);
        chk("flush2_csum", 32'(out_csum), 32'hFF);
        idle(1'b1);
        byte_in(8'hA5, 1'b1);
        byte_in(8'h5A, 1'b1);
        tick(1'b1, 1'b1, 8'h01, 1'b1, 1'b1);
        chk("flush3_data", out_data, 32'h00015AA5);
        chk("flush3_count", 32'(out_count), 32'd3);
        chk("flush3_csum", 32'(out_csum), 32'hFE);
        idle(1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("flush0_level", 32'(level), 32'h0);
        chk("flush0_valid", 32'(out_valid), 32'h0);

        // Gapped input
        byte_in(8'h01, 1'b1);
        idle(1'b1);
        idle(1'b1);
        byte_in(8'h02, 1'b1);
        byte_in(8'h03, 1'b1);
        idle(1'b1);
        chk("gap_early_valid", 32'(out_valid), 32'h0);
        byte_in(8'h04, 1'b1);
        chk("gap_data", out_data, 32'h04030201);
        chk("gap_csum", 32'(out_csum), 32'h04);
        idle(1'b1);

        // Overflow: five words with the consumer stalled
        for (int i = 0; i < 20; i++) byte_in(8'(i + 1), 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_head", out_data, 32'h04030201);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        chk("ovf_drained", 32'(level), 32'h0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Push on full with a simultaneous pop
        for (int i = 0; i < 19; i++) byte_in(8'(8'h40 + i), 1'b0);
        chk("pf_level_full", 32'(level), 32'd4);
        byte_in(8'h99, 1'b1);
        chk("pf_overflow", 32'(overflow), 32'h0);
        chk("pf_level", 32'(level), 32'd4);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("pf_last_word", out_data, 32'h99525150);
        idle(1'b1);

        // Reset mid-operation
        for (int i = 0; i < 11; i++) byte_in(8'(8'hC0 + i), 1'b0);
        tick(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        byte_in(8'hDE, 1'b1);
        byte_in(8'hAD, 1'b1);
        byte_in(8'hBE, 1'b1);
        byte_in(8'hEF, 1'b1);
        chk("rst_data", out_data, 32'hEFBEADDE);
        chk("rst_count", 32'(out_count), 32'd4);
        chk("rst_csum", 32'(out_csum), 32'h22);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
